angle_stepper: RTL and testbench
================================

ANGLE_STEPPER -- requirements
Module: angle_stepper

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATAW, `INT_BITS, signed angle width
- DW_BOUND, -180, lowest legal angle
- UP_BOUND, 179, highest legal angle
- HOLD_CYCLES, 25_000_000, press-held cycles before auto-repeat starts (>=1)
- REPEAT_CYCLES, 5_000_000, cycles between auto-repeat steps (>=1)
- ACCEL_AFTER, 8, auto-repeat steps before acceleration (used only with ANGLE_ACCEL_EN)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- inc_req  input  1  level request: rotate +1 (debounced upstream)
- dec_req  input  1  level request: rotate -1 (debounced upstream)
- load_en  input  1  one-cycle strobe: overwrite angle
- load_value  input  DATAW  signed value for load_en
- angle  output  DATAW  registered signed current angle
- step_pulse  output  1  registered; high one cycle per angle change caused by inc/dec

Function
REQ-003 The block SHALL treat the request as active when exactly one of inc_req/dec_req is high; both high or both low is "no request".
REQ-004 The FSM SHALL have states IDLE, HOLD and REPEAT, held in a registered state variable.
REQ-005 In IDLE, an active request SHALL step angle once (value visible the next cycle, step_pulse high that same cycle), clear the cycle counter, and enter HOLD.
REQ-006 In HOLD, the counter SHALL increment each cycle; once HOLD_CYCLES cycles have elapsed since the entry step with the same request still active, the block SHALL step once, clear the counter and enter REPEAT.
REQ-007 In REPEAT, the block SHALL step once every REPEAT_CYCLES cycles while the same request remains active.
REQ-008 In HOLD or REPEAT, loss of the request (release or both high) SHALL return the FSM to IDLE next cycle with no step.
REQ-009 In HOLD or REPEAT, a direction reversal (inc->dec or dec->inc in one cycle) SHALL behave as a fresh press: immediate step in the new direction, counter cleared, state HOLD.
REQ-010 Stepping SHALL wrap: +1 from UP_BOUND gives DW_BOUND; -1 from DW_BOUND gives UP_BOUND; otherwise +/-1.
REQ-011 load_en SHALL take priority over any step in its cycle: angle <= load_value if DW_BOUND <= load_value <= UP_BOUND; otherwise angle unchanged. In both cases step_pulse stays low and the FSM goes to IDLE.
REQ-012 After a load, a request still held SHALL be handled as a new press from IDLE on the next cycle.
REQ-013 The counter SHALL be wide enough for max(HOLD_CYCLES, REPEAT_CYCLES) and SHALL never wrap.

Reset
REQ-014 While reset is high at a clock edge: angle = 0, step_pulse = 0, state = IDLE, counters = 0; reset SHALL override load_en and requests.
REQ-015 A request held through reset deassertion SHALL be handled as a new press on the first cycle after reset.

Configuration
REQ-016 With macro ANGLE_ACCEL_EN defined, after ACCEL_AFTER REPEAT steps in one hold, the repeat period SHALL become max(1, REPEAT_CYCLES/2) until the FSM leaves REPEAT; the repeat-step count SHALL reset on leaving REPEAT.
REQ-017 Without ANGLE_ACCEL_EN, the repeat period SHALL stay REPEAT_CYCLES and no repeat-step counter SHALL be synthesised.

Structure
REQ-018 The FSM state enum typedef SHALL live in the shared control package; DATAW default and bounds SHALL come from rtl/math/constants.h.
REQ-019 Wrap arithmetic SHALL be done by instantiating the existing circular_step sub-module (same DATAW/DW_BOUND/UP_BOUND); no duplicated wrap logic.

Verification (HOLD_CYCLES=4, REPEAT_CYCLES=2, ACCEL_AFTER=3)
REQ-020 Tap: angle=10, inc_req high 1 cycle -> angle=11, exactly one step_pulse, FSM back to IDLE.
REQ-021 Hold: dec_req high 12 cycles from angle=0 -> steps at cycles 1, 5, 7, 9, 11; final angle=-5.
REQ-022 Wrap: load 179, inc tap -> -180; then dec tap -> 179.
REQ-023 Reversal/both: hold inc 6 cycles, switch to dec -> immediate -1 step and HOLD restart; inc+dec both high -> no steps, IDLE.
REQ-024 Load: load_en with inc step due -> angle=load_value, no step_pulse; load_value=200 -> angle unchanged.
REQ-025 Accel (ANGLE_ACCEL_EN): hold inc 20 cycles -> repeat spacing 2 for first 3 repeats then 1; without macro spacing stays 2; reset mid-hold -> angle=0, IDLE.

Source files
------------

// File: rtl/angle_stepper_pkg.sv
// Shared control package for angle_stepper: angle constants, FSM state type, sizing helpers.
package angle_stepper_pkg;

    localparam int unsigned ANGLE_INT_BITS = 9;
    localparam int          ANGLE_DW_BOUND = -180;
    localparam int          ANGLE_UP_BOUND = 179;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold 0 .. n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/circular_step.sv
// circular_step: +/-1 on a signed angle, wrapping between DW_BOUND and UP_BOUND.
module circular_step
    import angle_stepper_pkg::*;
#(
    parameter int unsigned DATAW    = ANGLE_INT_BITS,
    parameter int          DW_BOUND = ANGLE_DW_BOUND,
    parameter int          UP_BOUND = ANGLE_UP_BOUND
) (
    input  logic signed [DATAW-1:0] i_angle,
    input  logic                    i_up,
    output logic signed [DATAW-1:0] o_next_c
);

    localparam logic signed [DATAW-1:0] LO_V  = DATAW'(DW_BOUND);
    localparam logic signed [DATAW-1:0] HI_V  = DATAW'(UP_BOUND);
    localparam logic signed [DATAW-1:0] ONE_V = DATAW'(1);

    // Wrapped neighbour of the current angle in the requested direction.
    always_comb begin
        o_next_c = i_angle;
        if (i_up) begin
            o_next_c = (i_angle == HI_V) ? LO_V : i_angle + ONE_V;
        end else begin
            o_next_c = (i_angle == LO_V) ? HI_V : i_angle - ONE_V;
        end
    end

endmodule

// File: rtl/angle_stepper.sv
// angle_stepper: button-driven wrapping angle with tap, hold-delay and auto-repeat.
// Optional macro ANGLE_ACCEL_EN: halve the repeat period after ACCEL_AFTER repeat steps.
module angle_stepper
    import angle_stepper_pkg::*;
#(
    parameter int unsigned DATAW         = ANGLE_INT_BITS,
    parameter int          DW_BOUND      = ANGLE_DW_BOUND,
    parameter int          UP_BOUND      = ANGLE_UP_BOUND,
    parameter int unsigned HOLD_CYCLES   = 25_000_000,
    parameter int unsigned REPEAT_CYCLES = 5_000_000,
    parameter int unsigned ACCEL_AFTER   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc_req,
    input  logic                    dec_req,
    input  logic                    load_en,
    input  logic signed [DATAW-1:0] load_value,
    output logic signed [DATAW-1:0] angle,
    output logic                    step_pulse
);

    localparam int unsigned CNT_W = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic signed [DATAW-1:0] LO_V = DATAW'(DW_BOUND);
    localparam logic signed [DATAW-1:0] HI_V = DATAW'(UP_BOUND);

    step_state_e             r_state;
    step_state_e             w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic signed [DATAW-1:0] r_angle;
    logic signed [DATAW-1:0] w_angle_nxt;
    logic                    r_pulse;
    logic                    w_pulse_nxt;
    logic                    r_dir_up;
    logic                    w_dir_up_nxt;
    logic                    w_active;
    logic                    w_rep_step;
    logic [CNT_W-1:0]        w_rep_last;
    logic signed [DATAW-1:0] w_stepped;
    logic                    w_load_ok;

    assign w_active  = inc_req ^ dec_req;
    assign w_load_ok = (load_value >= LO_V) && (load_value <= HI_V);

    // Any step always moves in the direction of the live request.
    circular_step #(
        .DATAW    (DATAW),
        .DW_BOUND (DW_BOUND),
        .UP_BOUND (UP_BOUND)
    ) u_circular_step (
        .i_angle  (r_angle),
        .i_up     (inc_req),
        .o_next_c (w_stepped)
    );

`ifdef ANGLE_ACCEL_EN
    localparam int unsigned REP_W = cnt_width(ACCEL_AFTER + 1);
    localparam int unsigned REPEAT_FAST = (REPEAT_CYCLES / 2 > 0) ? REPEAT_CYCLES / 2 : 1;
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(REPEAT_FAST - 1);
    localparam logic [REP_W-1:0] REP_SAT   = REP_W'(ACCEL_AFTER);

    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_nxt;

    // Repeat period shortens once enough repeat steps have happened in this hold.
    always_comb begin
        w_rep_last = (r_rep_cnt == REP_SAT) ? FAST_LAST : REP_LAST;
        w_rep_nxt  = r_rep_cnt;
        if (w_state_nxt != ST_REPEAT) begin
            w_rep_nxt = '0;
        end else if (w_rep_step && (r_rep_cnt != REP_SAT)) begin
            w_rep_nxt = r_rep_cnt + REP_W'(1);
        end
    end

    // Saturating count of repeat steps, cleared whenever REPEAT is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= w_rep_nxt;
        end
    end
`else
    logic w_unused_accel;
    assign w_unused_accel = ^{32'(ACCEL_AFTER), w_rep_step};
    assign w_rep_last     = REP_LAST;
`endif

    // Next-state, counter, angle and pulse; load overrides any step.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_angle_nxt  = r_angle;
        w_pulse_nxt  = 1'b0;
        w_dir_up_nxt = r_dir_up;
        w_rep_step   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_active) begin
                    w_angle_nxt  = w_stepped;
                    w_pulse_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_dir_up_nxt = inc_req;
                    w_state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!w_active) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (inc_req != r_dir_up) begin
                    w_angle_nxt  = w_stepped;
                    w_pulse_nxt  = 1'b1;
                    w_cnt_nxt    = '0;
                    w_dir_up_nxt = inc_req;
                    w_state_nxt  = ST_HOLD;
                end else if (r_cnt == ((r_state == ST_HOLD) ? HOLD_LAST : w_rep_last)) begin
                    w_angle_nxt = w_stepped;
                    w_pulse_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_rep_step  = (r_state == ST_REPEAT);
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (load_en) begin
            w_angle_nxt = w_load_ok ? load_value : r_angle;
            w_pulse_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_rep_step  = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_angle  <= '0;
            r_pulse  <= 1'b0;
            r_dir_up <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_angle  <= w_angle_nxt;
            r_pulse  <= w_pulse_nxt;
            r_dir_up <= w_dir_up_nxt;
        end
    end

    assign angle      = r_angle;
    assign step_pulse = r_pulse;

endmodule

// File: tb/tb_angle_stepper.sv
// Testbench for angle_stepper: directed scenarios plus random stimulus vs. a timeline model.
module tb_angle_stepper;

    localparam int HOLD  = 4;
    localparam int REP   = 2;
    localparam int ACCEL = 3;
    localparam int FAST  = (REP / 2 > 0) ? REP / 2 : 1;
    localparam int LO    = -180;
    localparam int HI    = 179;
`ifdef ANGLE_ACCEL_EN
    localparam bit ACCEL_ON = 1'b1;
`else
    localparam bit ACCEL_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              inc_req = 1'b0;
    logic              dec_req = 1'b0;
    logic              load_en = 1'b0;
    logic signed [8:0] load_value = '0;
    logic signed [8:0] angle;
    logic              step_pulse;

    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;

    // Model: press timeline measured in cycles since the press step.
    int m_angle = 0;
    int m_dir = 0;
    int m_elapsed = 0;
    int m_due = 0;
    int m_nrep = 0;
    bit m_hold_done = 1'b0;
    int e_pulse = 0;

    always #5 clk = ~clk;

    angle_stepper #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .ACCEL_AFTER   (ACCEL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inc_req    (inc_req),
        .dec_req    (dec_req),
        .load_en    (load_en),
        .load_value (load_value),
        .angle      (angle),
        .step_pulse (step_pulse)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input int r);
        m_angle = m_angle + r;
        if (m_angle > HI) m_angle = LO;
        if (m_angle < LO) m_angle = HI;
        e_pulse = 1;
    endtask

    task automatic model(input logic a_inc, input logic a_dec, input logic a_ld,
                         input int a_lv, input logic a_rst);
        int r;
        e_pulse = 0;
        if (a_rst) begin
            m_angle = 0;
            m_dir   = 0;
        end else if (a_ld) begin
            if (a_lv >= LO && a_lv <= HI) m_angle = a_lv;
            m_dir = 0;
        end else begin
            r = (a_inc && !a_dec) ? 1 : ((a_dec && !a_inc) ? -1 : 0);
            if (r == 0) begin
                m_dir = 0;
            end else if (r != m_dir) begin
                model_step(r);
                m_dir       = r;
                m_elapsed   = 0;
                m_due       = HOLD;
                m_nrep      = 0;
                m_hold_done = 1'b0;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_due) begin
                    model_step(r);
                    if (!m_hold_done) begin
                        m_hold_done = 1'b1;
                        m_due += REP;
                    end else begin
                        m_nrep++;
                        m_due += (ACCEL_ON && m_nrep >= ACCEL) ? FAST : REP;
                    end
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic cyc(input logic a_inc, input logic a_dec, input logic a_ld,
                       input int a_lv, input logic a_rst, input string tag);
        @(negedge clk);
        inc_req    = a_inc;
        dec_req    = a_dec;
        load_en    = a_ld;
        load_value = 9'(a_lv);
        reset      = a_rst;
        model(a_inc, a_dec, a_ld, a_lv, a_rst);
        @(posedge clk);
        #1;
        check({tag, "_angle"}, int'(angle), m_angle);
        check({tag, "_pulse"}, int'(step_pulse), e_pulse);
        n_pulse += int'(step_pulse);
    endtask

    initial begin
        int mode;
        int run;
        logic ri, rd, rl, rr;
        int lv;

        cyc(0, 0, 0, 0, 1, "rst");
        cyc(0, 0, 0, 0, 1, "rst");
        check("rst_angle", int'(angle), 0);

        // Tap
        cyc(0, 0, 1, 10, 0, "ld10");
        n_pulse = 0;
        cyc(1, 0, 0, 0, 0, "tap");
        cyc(0, 0, 0, 0, 0, "tap_rel");
        cyc(0, 0, 0, 0, 0, "tap_rel");
        check("tap_angle", int'(angle), 11);
        check("tap_pulses", n_pulse, 1);
        cyc(1, 0, 0, 0, 0, "retap");
        check("retap_angle", int'(angle), 12);
        cyc(0, 0, 0, 0, 0, "retap_rel");

        // Hold down for 12 cycles
        cyc(0, 0, 1, 0, 0, "ld0");
        n_pulse = 0;
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, "hold");
        check("hold_angle", int'(angle), -5);
        check("hold_pulses", n_pulse, 5);
        cyc(0, 0, 0, 0, 0, "hold_rel");

        // Wrap both ways
        cyc(0, 0, 1, 179, 0, "ld179");
        cyc(1, 0, 0, 0, 0, "wrap_up");
        check("wrap_up_angle", int'(angle), -180);
        cyc(0, 0, 0, 0, 0, "wrap_rel");
        cyc(0, 1, 0, 0, 0, "wrap_dn");
        check("wrap_dn_angle", int'(angle), 179);
        cyc(0, 0, 0, 0, 0, "wrap_rel");

        // Reversal and both-high
        cyc(0, 0, 1, 0, 0, "ld0");
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0, "rev_inc");
        cyc(0, 1, 0, 0, 0, "rev_dec");
        check("rev_angle", int'(angle), 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, "rev_hold");
        check("rev_hold_angle", int'(angle), 0);
        n_pulse = 0;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, "both");
        check("both_pulses", n_pulse, 0);
        cyc(0, 0, 0, 0, 0, "both_rel");

        // Load while a hold step is due, then out-of-range load
        cyc(0, 0, 1, 0, 0, "ld0");
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, "ldh_inc");
        cyc(1, 0, 1, 50, 0, "ld_due");
        check("ld_due_angle", int'(angle), 50);
        cyc(1, 0, 0, 0, 0, "ld_repress");
        check("ld_repress_angle", int'(angle), 51);
        cyc(1, 0, 1, 200, 0, "ld_oor");
        check("ld_oor_angle", int'(angle), 51);
        cyc(0, 0, 0, 0, 0, "ld_rel");

        // Long hold (acceleration when enabled), then reset mid-hold
        cyc(0, 0, 1, 0, 0, "ld0");
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, "accel");
        check("accel_angle", int'(angle), ACCEL_ON ? 14 : 9);
        cyc(1, 0, 0, 0, 1, "mid_rst");
        check("mid_rst_angle", int'(angle), 0);
        cyc(1, 0, 0, 0, 0, "post_rst");
        check("post_rst_angle", int'(angle), 1);
        cyc(0, 0, 0, 0, 0, "post_rel");

        // Random runs of held requests with sparse loads and resets
        for (int k = 0; k < 250; k++) begin
            mode = int'($urandom_range(0, 7));
            run  = int'($urandom_range(1, 16));
            ri = (mode == 1 || mode == 3 || mode == 4 || mode == 6);
            rd = (mode == 2 || mode == 3 || mode == 5 || mode == 7);
            for (int j = 0; j < run; j++) begin
                rl = ($urandom_range(0, 39) == 0);
                rr = ($urandom_range(0, 149) == 0);
                lv = int'($urandom_range(0, 511)) - 256;
                if ($urandom_range(0, 3) == 0) lv = int'($urandom_range(0, 2)) ? HI : LO;
                cyc(ri, rd, rl, lv, rr, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
